// File: rtl/ip_codma_bus_responder_if.sv
// Bus bundle between a codma DMA master and the memory-side responder.
// Handshake: the master holds req_i (with write_i/addr_i/size_i) until grant_o
// pulses; read beats move on every read_valid_o cycle and write beats on every
// write_valid_i cycle while the responder is in its write-data phase. There is
// no backpressure, so a valid beat is always consumed in the cycle it appears.
interface ip_codma_bus_responder_if;
    logic        req_i;
    logic        write_i;
    logic [31:0] addr_i;
    logic [3:0]  size_i;
    logic        abort_i;
    logic        grant_o;
    logic        read_valid_o;
    logic [63:0] read_data_o;
    logic        write_valid_i;
    logic [63:0] write_data_i;
    logic        error_o;
    logic        busy_o;

    modport master (
        output req_i, write_i, addr_i, size_i, abort_i, write_valid_i, write_data_i,
        input  grant_o, read_valid_o, read_data_o, error_o, busy_o
    );

    modport slave (
        input  req_i, write_i, addr_i, size_i, abort_i, write_valid_i, write_data_i,
        output grant_o, read_valid_o, read_data_o, error_o, busy_o
    );
endinterface

// File: rtl/ip_codma_bus_responder.sv
// Memory-side responder for the codma bus: grants one burst at a time and
// serves reads from / absorbs writes into an internal 64-bit beat memory.
module ip_codma_bus_responder #(
    parameter int DEPTH_BEATS = 256,
    parameter int RD_LATENCY  = 2,
    parameter int WR_TIMEOUT  = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    ip_codma_bus_responder_if.slave    bus,
    output logic [2:0]                 dbg_state_o
);

    localparam int IDX_W = $clog2(DEPTH_BEATS);
    localparam int IW1   = IDX_W + 1;
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int TO_W  = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_RD_WAIT, S_RD_DATA, S_WR_DATA, S_ERROR
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [2:0]         beats_q;
    logic [2:0]         cnt_q;
    logic               wr_q;
    logic [LAT_W-1:0]   wait_q;
    logic [TO_W-1:0]    to_q;
    logic               grant_q;
    logic               read_valid_q;
    logic [63:0]        read_data_q;
    logic               error_q;
    logic               busy_q;
    logic [63:0]        mem_q [DEPTH_BEATS];

    logic [IDX_W-1:0]   req_idx;
    logic [2:0]         req_beats;
    logic [IDX_W:0]     req_last;
    logic               req_legal;

    assign req_idx = bus.addr_i[IDX_W+2:3];

    always_comb begin
        req_beats = 3'd0;
        case (bus.size_i)
            4'd3:    req_beats = 3'd1;
            4'd8:    req_beats = 3'd3;
            4'd9:    req_beats = 3'd4;
            default: req_beats = 3'd0;
        endcase
    end

    // One extra bit catches bursts that would run past the top of memory.
    assign req_last  = {1'b0, req_idx} + IW1'(req_beats) - IW1'(1);
    assign req_legal = (req_beats != 3'd0) && (bus.addr_i[2:0] == 3'd0) && !req_last[IDX_W];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            beats_q      <= '0;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            wait_q       <= '0;
            to_q         <= '0;
            grant_q      <= 1'b0;
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            grant_q      <= 1'b0;
            error_q      <= 1'b0;
            read_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req_i) begin
                        ptr_q   <= req_idx;
                        beats_q <= req_beats;
                        wr_q    <= bus.write_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        if (req_legal) begin
                            state_q <= S_GRANT;
                            grant_q <= 1'b1;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_GRANT: begin
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (wr_q) begin
                        state_q <= S_WR_DATA;
                        to_q    <= '0;
                    end else if (RD_LATENCY == 0) begin
                        state_q      <= S_RD_DATA;
                        read_valid_q <= 1'b1;
                        read_data_q  <= mem_q[ptr_q];
                        ptr_q        <= ptr_q + 1'b1;
                        cnt_q        <= cnt_q + 1'b1;
                    end else begin
                        state_q <= S_RD_WAIT;
                        wait_q  <= '0;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (wait_q == LAT_W'(RD_LATENCY - 1)) begin
                        state_q      <= S_RD_DATA;
                        read_valid_q <= 1'b1;
                        read_data_q  <= mem_q[ptr_q];
                        ptr_q        <= ptr_q + 1'b1;
                        cnt_q        <= cnt_q + 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (bus.abort_i || (cnt_q == beats_q)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        read_valid_q <= 1'b1;
                        read_data_q  <= mem_q[ptr_q];
                        ptr_q        <= ptr_q + 1'b1;
                        cnt_q        <= cnt_q + 1'b1;
                    end
                end
                S_WR_DATA: begin
                    // The memory array itself captures a beat even when abort_i coincides.
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (bus.write_valid_i) begin
                        ptr_q <= ptr_q + 1'b1;
                        cnt_q <= cnt_q + 1'b1;
                        to_q  <= '0;
                        if (cnt_q == beats_q - 3'd1) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (to_q == TO_W'(WR_TIMEOUT - 1)) begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                S_ERROR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if ((state_q == S_WR_DATA) && bus.write_valid_i) begin
            mem_q[ptr_q] <= bus.write_data_i;
        end
    end

    assign bus.grant_o      = grant_q;
    assign bus.read_valid_o = read_valid_q;
    assign bus.read_data_o  = read_data_q;
    assign bus.error_o      = error_q;
    assign bus.busy_o       = busy_q;
    assign dbg_state_o      = state_q;

endmodule

// File: doc/ip_codma_bus_responder.md
Name: ip_codma_bus_responder

Overview:
- Bus-side responder (slave/memory model) for the codma bus protocol.
- Accepts one read or write burst request at a time, grants it, and serves it:
  - reads: returns 64-bit data beats from an internal word memory;
  - writes: absorbs 64-bit beats into that memory.
- Sits opposite the DMA read/write machines. Used as the system-memory endpoint in subsystem simulation and as a synthesizable scratch RAM.
- Flags illegal requests and stalled write bursts on error_o.

Parameters:
- DEPTH_BEATS, 256: memory depth in 64-bit entries (power of 2).
- RD_LATENCY, 2: idle cycles between the grant cycle and the first read_valid_o (0 allowed).
- WR_TIMEOUT, 16: consecutive cycles in WR_DATA without write_valid_i before an error is raised.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- req_i  in  1  master request, level; sampled only in IDLE
- write_i  in  1  1=write burst, 0=read burst; sampled with req_i
- addr_i  in  32  byte address of first word; sampled with req_i
- size_i  in  4  burst size code: 3=1 beat (2 words), 8=3 beats (6 words), 9=4 beats (8 words)
- abort_i  in  1  stop current transfer, return to IDLE
- grant_o  out  1  one-cycle grant pulse
- read_valid_o  out  1  read beat valid
- read_data_o  out  64  read beat; [31:0]=word at lower address, [63:32]=next word
- write_valid_i  in  1  write beat valid
- write_data_i  in  64  write beat; same word ordering as read_data_o
- error_o  out  1  one-cycle error pulse
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Memory contents are not reset. Reset mid-burst aborts immediately with no further valid beats.
- All outputs are registered (driven from state/registers, no input-to-output comb paths).
- Beat index = addr_i[log2(DEPTH_BEATS)+2:3].
- States: IDLE, GRANT, RD_WAIT, RD_DATA, WR_DATA, ERROR.
- IDLE:
  - req_i=1 in cycle N latches addr, size, write.
  - Illegal request goes to ERROR. Illegal means: size not in {3,8,9}; addr_i[2:0]!=0; or first beat index + beats - 1 >= DEPTH_BEATS (no wrap).
  - Otherwise go to GRANT.
- GRANT: grant_o=1 for exactly cycle N+1. Next state:
  - write: WR_DATA;
  - read with RD_LATENCY>0: RD_WAIT;
  - read with RD_LATENCY=0: RD_DATA.
- RD_WAIT: stays exactly RD_LATENCY cycles, then RD_DATA.
- RD_DATA:
  - read_valid_o=1 on consecutive cycles, one beat per cycle, pointer incrementing by 1.
  - First beat appears at cycle N+2+RD_LATENCY.
  - After the last beat (beat count = size beats): IDLE, read_valid_o=0 the following cycle.
  - No backpressure.
- WR_DATA:
  - Each cycle with write_valid_i=1 writes write_data_i to mem[ptr]; ptr and beat count increment.
  - After the final beat is accepted: IDLE.
  - write_valid_i outside WR_DATA is ignored (GRANT cycle included).
  - Timeout counter resets on each accepted beat. Reaching WR_TIMEOUT idle cycles goes to ERROR. Beats already written stay written.
- ERROR: error_o=1 for one cycle, then IDLE. No grant for illegal requests.
- abort_i=1 in any non-IDLE state forces IDLE next cycle.
  - read_valid_o is 0 from the next cycle onward.
  - A write beat coinciding with abort_i is still written.
  - No error_o is raised.
  - abort_i beats a same-cycle timeout.
- req_i held high after completion starts a new request from IDLE; back-to-back transfers are separated by at least 1 IDLE cycle.
- busy_o=0 only in IDLE.

Test Plan:
- Write size 9 at addr 0x40 (beats 8..11), data 0x1111_0000+k for k=0..3, write_valid_i held high from N+2 -> grant_o at N+1, idle at N+6, no error_o. Then read size 9 from 0x40 with RD_LATENCY=2 -> read_valid_o high at cycles M+4..M+7 with the same 4 values in order.
- Read size 3 at 0x0 with RD_LATENCY=0 -> grant_o at N+1, single read_valid_o at N+2, busy_o low at N+3.
- Illegal requests: size=5; addr=0x44; size 9 at index DEPTH_BEATS-2 -> each gives error_o pulse at N+1, grant_o never asserted, back in IDLE.
- Write size 8, deliver 1 beat then hold write_valid_i=0 for WR_TIMEOUT cycles -> error_o pulse; first beat present in memory, beats 2-3 unchanged.
- Read size 9, assert abort_i on the 2nd read beat -> exactly 2 beats seen, IDLE next cycle, no error_o. A subsequent request is granted normally.
- Assert reset_n_i low mid write burst -> all outputs 0 asynchronously. After release, a read of the already-written beats returns the pre-reset data.
